// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and buffers
// responses in a prefetch FIFO for decode. Optional counters behind FETCH_PERF_EN.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {S_FETCH, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outs_q, outs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic          req_hs, push, pop;
    logic [31:0]   redirect_addr;
    logic          unused_redirect_lsbs;

    assign redirect_addr        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit rule: FIFO slots plus in-flight requests never exceed DEPTH.
    always_comb begin
        imem_req_valid = !rst && (state_q == S_FETCH) && !redirect &&
                         (({1'b0, cnt_q} + {1'b0, outs_q}) < DEPTH_W);
        imem_req_addr  = pc_q;
        out_valid      = !rst && (cnt_q != '0) && !redirect;
        out_instr      = '0;
        out_pc         = '0;
        if (!rst && (cnt_q != '0)) begin
            out_instr = instr_mem[rd_q];
            out_pc    = pc_mem[rd_q];
        end
        req_hs = imem_req_valid && imem_req_ready;
        pop    = out_valid && out_ready;
        push   = !rst && imem_rsp_valid && (state_q == S_FETCH) && !redirect;
    end

    // NOTE: every next-state signal gets its hold value first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outs_d   = outs_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rd_d     = rd_q;

        if (req_hs && !imem_rsp_valid)      outs_d = outs_q + CW'(1);
        else if (!req_hs && imem_rsp_valid) outs_d = outs_q - CW'(1);

        if (req_hs) pc_d = pc_q + 32'd4;
        if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_d     = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);

        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);

        if (redirect) begin
            pc_d     = redirect_addr;
            rsp_pc_d = redirect_addr;
            cnt_d    = '0;
            wr_d     = '0;
            rd_d     = '0;
            state_d  = (outs_d != '0) ? S_DRAIN : S_FETCH;
        end else if ((state_q == S_DRAIN) && (outs_d == '0)) begin
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outs_q   <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outs_q   <= outs_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    // NOTE: storage is not reset; cnt_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_q] <= imem_rsp_data;
            pc_mem[wr_q]    <= rsp_pc_q;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (cnt_q == CW'(DEPTH))));

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, dropped_q;
    logic [32:0] fetched_sum, dropped_sum;
    logic [CW:0] drop_n;
    logic        drop;

    always_comb begin
        drop        = !rst && imem_rsp_valid && !push;
        drop_n      = (CW + 1)'(drop) + (redirect ? {1'b0, cnt_q} : '0);
        fetched_sum = {1'b0, fetched_q} + 33'(pop);
        dropped_sum = {1'b0, dropped_q} + 33'(drop_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            dropped_q <= dropped_sum[32] ? '1 : dropped_sum[31:0];
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`else
    // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, variable-latency memory model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, redirect, imem_req_ready, imem_rsp_valid, out_ready;
    logic [31:0] redirect_pc, imem_rsp_data;
    logic        imem_req_valid, out_valid;
    logic [31:0] imem_req_addr, out_instr, out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model: decode-visible FIFO, PCs of live requests, count of stale responses.
    ent_t        fq[$];
    logic [31:0] live[$];
    int          stale = 0;
    logic [31:0] m_pc = RESET_PC;
    int          m_fetched = 0, m_dropped = 0;

    // Memory model: in-order responses with due cycles.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0, last_due = 0;
    int          lat_lo = 1, lat_hi = 1;

    int n_checks = 0, n_errors = 0;

    logic        s_req_valid, s_out_valid, s_rsp;
    logic [31:0] s_req_addr, s_out_pc, s_out_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the negedge, compare against the model, advance the model.
    task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit ordy, input bit qrdy);
        bit          e_rv, e_ov, hs, pp;
        int          due;
        logic [31:0] p;
        rst            = r;
        redirect       = rd;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = qrdy;
        if (!r && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        s_rsp       = imem_rsp_valid;

        e_rv = !r && (stale == 0) && !rd && (fq.size() + live.size() < DEPTH);
        e_ov = !r && (fq.size() > 0) && !rd;
        check("req_valid", 32'(imem_req_valid), 32'(e_rv));
        if (e_rv) check("req_addr", imem_req_addr, m_pc);
        check("out_valid", 32'(out_valid), 32'(e_ov));
        if (e_ov) begin
            check("out_pc", out_pc, fq[0].pc);
            check("out_instr", out_instr, fq[0].instr);
        end
        if (r) begin
            check("rst_out_pc", out_pc, 32'h0);
            check("rst_out_instr", out_instr, 32'h0);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 32'(m_fetched));
        check("perf_dropped", perf_dropped, 32'(m_dropped));
`endif

        if (r) begin
            fq.delete(); live.delete(); pend_addr.delete(); pend_due.delete();
            stale = 0; m_pc = RESET_PC; m_fetched = 0; m_dropped = 0;
            last_due = cyc;
        end else begin
            hs = e_rv && qrdy;
            pp = e_ov && ordy;
            if (imem_rsp_valid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                if (stale > 0) begin
                    stale--;
                    m_dropped++;
                end else begin
                    p = live.pop_front();
                    if (rd) m_dropped++;
                    else    fq.push_back('{instr: mem_word(p), pc: p});
                end
            end
            if (rd) begin
                m_dropped += fq.size();
                stale     += live.size();
                live.delete();
                fq.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else if (pp) begin
                void'(fq.pop_front());
                m_fetched++;
            end
            if (hs) begin
                live.push_back(m_pc);
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(m_pc);
                pend_due.push_back(due);
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        bit found;

        // Reset release, 1-cycle memory, streaming at one instruction per cycle.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        check("rst_req_valid", 32'(s_req_valid), 32'h0);
        check("rst_out_valid", 32'(s_out_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 1);
            if (k == 0) begin
                check("t1_first_req", 32'(s_req_valid), 32'h1);
                check("t1_first_addr", s_req_addr, RESET_PC);
            end
            if (k >= 2) begin
                check("t1_valid", 32'(s_out_valid), 32'h1);
                check("t1_pc", s_out_pc, 32'(4 * (k - 2)));
                check("t1_instr", s_out_instr, mem_word(32'(4 * (k - 2))));
            end
        end

        // Decode stalled: credit limits accepted requests to DEPTH.
        do_reset();
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 1);
            if (s_req_valid) acc++;
        end
        check("t2_accepted", 32'(acc), 32'd4);
        check("t2_req_blocked", 32'(s_req_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 1);
            check("t2_valid", 32'(s_out_valid), 32'h1);
            check("t2_pc", s_out_pc, 32'(4 * k));
            if (k == 1) begin
                check("t2_resume_req", 32'(s_req_valid), 32'h1);
                check("t2_resume_addr", s_req_addr, 32'd16);
            end
        end

        // 3-cycle memory, redirect with two requests in flight.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h100, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t3_drain_blk0", 32'(s_req_valid), 32'h0);
        step(0, 0, 0, 1, 1);
        check("t3_drain_blk1", 32'(s_req_valid), 32'h0);
        check("t3_stale_rsp", 32'(s_rsp), 32'h1);
        step(0, 0, 0, 1, 1);
        check("t3_new_req", 32'(s_req_valid), 32'h1);
        check("t3_new_addr", s_req_addr, 32'h100);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(0, 0, 0, 1, 1);
            if (s_out_valid) begin
                found = 1;
                check("t3_first_pc", s_out_pc, 32'h100);
            end
        end
        check("t3_found", 32'(found), 32'h1);

        // Redirect coinciding with a response and out_ready, two entries buffered.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
        step(0, 1, 32'h200, 1, 1);
        check("t4_rsp_in_redirect", 32'(s_rsp), 32'h1);
        check("t4_masked_valid", 32'(s_out_valid), 32'h0);
        step(0, 0, 0, 1, 1);
        check("t4_fifo_cleared", 32'(s_out_valid), 32'h0);
        check("t4_req_addr", s_req_addr, 32'h200);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t4_out_valid", 32'(s_out_valid), 32'h1);
        check("t4_out_pc", s_out_pc, 32'h200);

        // Unaligned redirect target and PC wrap.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_0103, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t5_align_valid", 32'(s_req_valid), 32'h1);
        check("t5_align_addr", s_req_addr, 32'h100);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1);
        step(0, 1, 32'hFFFF_FFFB, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 1);
            check("t5_wrap_valid", 32'(s_out_valid), 32'h1);
            check("t5_wrap_pc", s_out_pc, 32'hFFFF_FFF8 + 32'(4 * k));
        end

        // Reset in the middle of a drain.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h300, 1, 1);
        step(1, 0, 0, 1, 1);
        check("t6_rst_req_valid", 32'(s_req_valid), 32'h0);
        check("t6_rst_out_valid", 32'(s_out_valid), 32'h0);
        step(0, 0, 0, 1, 1);
        check("t6_req_valid", 32'(s_req_valid), 32'h1);
        check("t6_req_addr", s_req_addr, RESET_PC);

        // Randomized traffic.
        for (int blk = 0; blk < 6; blk++) begin
            lat_lo = 1;
            lat_hi = 1 + (blk % 4);
            for (int k = 0; k < 500; k++) begin
                logic [31:0] rpc;
                rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
                step(($urandom_range(199) == 0), ($urandom_range(19) == 0), rpc,
                     ($urandom_range(9) < 6), ($urandom_range(9) < 7));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode / register-read pipeline register.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel with variable response latency.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- On a redirect (taken branch/jump), flushes the FIFO and discards all stale in-flight responses.

Parameters:
- DEPTH, 4, prefetch FIFO entries and the max of (FIFO occupancy + outstanding requests); power of 2, ≥2.
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect  input  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid. In order, one per accepted request, never back-pressured, earliest the cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- out_valid  output  1  instruction available to decode.
- out_ready  input  1  decode accepts.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  32  PC of out_instr.

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, FIFO empty, outstanding=0, state=FETCH.
- Outputs during and after reset: imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0.
- rst overrides every other input.
- States:
  - FETCH: requests are issued.
  - DRAIN: every response is discarded and no requests are issued.
- Request rule:
  - imem_req_valid = (state==FETCH) && !redirect && (fifo_count + outstanding < DEPTH).
  - imem_req_addr = pc.
  - On handshake: pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC→0), outstanding += 1.
- Response in FETCH:
  - Push {imem_rsp_data, pc of that request} into the FIFO; outstanding -= 1.
  - A request PC FIFO (or a counter-derived PC) tracks request PCs.
  - FIFO overflow is impossible by the credit rule; a simulation assertion checks it.
- Output:
  - out_valid = FIFO not empty && !redirect.
  - out_instr/out_pc come from the FIFO head, combinationally.
  - Pop on out_valid && out_ready.
  - No combinational path from imem_rsp_* to out_*: minimum 1-cycle latency from response to out_valid.
- Redirect, in the cycle it is high:
  - No request issued.
  - No pop.
  - FIFO cleared at the edge.
  - pc <= {redirect_pc[31:2],2'b00}.
  - A response arriving in the same cycle is discarded and decrements outstanding.
  - Next state: DRAIN if outstanding after this cycle's accounting > 0, else FETCH.
- DRAIN:
  - Each response decrements outstanding and is dropped.
  - Go to FETCH the cycle after outstanding reaches 0.
  - A further redirect in DRAIN only updates pc and clears the FIFO.
- Throughput: with 1-cycle memory and out_ready=1, sustains 1 instr/cycle.
- Fetch-to-decode latency after a redirect with no stale traffic: request at cycle+1, out_valid at cycle+3 for 1-cycle memory.
- Simultaneous push and pop on a full FIFO: legal; count unchanged.
- Widths:
  - outstanding and fifo_count: $clog2(DEPTH+1) bits.
  - FIFO pointers: $clog2(DEPTH) bits, natural wrap.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched[31:0] and perf_dropped[31:0].
  - perf_fetched counts out handshakes.
  - perf_dropped counts discarded responses plus FIFO entries cleared by redirect.
  - Both reset to 0, saturate at 32'hFFFF_FFFF.
- Undefined: no ports, no counter logic; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, 1-cycle memory, out_ready=1 → requests to 0,4,8,…; out_pc 0,4,8 on consecutive cycles from cycle 3; words match memory.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid stays 0; on release, 4 instrs out in order with PCs 0..12, then fetch resumes at 16.
- 3-cycle memory latency, redirect to 0x100 with 2 requests in flight → state DRAIN, both responses dropped, no out_valid, first new request addr 0x100 after the second stale response; next out_pc=0x100.
- Redirect in the same cycle as rsp_valid and out_ready with 2 entries buffered → FIFO empty next cycle, no pop counted, response dropped, next out_pc=redirect_pc.
- redirect_pc=0x0000_0103 → fetch addr 0x100; pc reaching 0xFFFF_FFFC → next addr 0x0000_0000.
- rst asserted mid-DRAIN with outstanding=2 → all outputs 0, state FETCH, first request at RESET_PC; the bench drops pending memory responses on reset.
